alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter BITS, default 8, operand/result width; must match the ALU's BITS.
REQ-002 SHALL have parameter LOG2_BITS, default 3, log2(BITS); passed through unchanged to the attached ALU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream request valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a request this cycle.
REQ-007 SHALL have port in_a, in_b, in_op  input  BITS each  operands and opcode (op[4:0] opcode, op[7:5] modifier bits).
REQ-008 SHALL have port alu_a, alu_b, alu_op  output  BITS each  registered operands/opcode driven to the ALU.
REQ-009 SHALL have port alu_z  input  BITS  ALU result.
REQ-010 SHALL have port alu_flags  input  8  ALU flags {N/A,N/A,UNKNWN,DIV0,EQ,GT,UNDER,OVER}, bit0 = OVER.
REQ-011 SHALL have port out_valid  output  1  result valid to downstream.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_z  output  BITS  captured result.
REQ-014 SHALL have port out_flags  output  8  flags captured with out_z.
REQ-015 SHALL have port status  output  8  sticky OR of all captured flags.
REQ-016 SHALL have port flag_clr  input  1  synchronous clear of status.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DONE; encoding is free.
REQ-019 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), combinationally.
REQ-020 SHALL accept a request on a rising edge where in_valid & in_ready; it then latches in_a/in_b/in_op into alu_a/alu_b/alu_op and goes to ISSUE.
REQ-021 SHALL hold alu_a/alu_b/alu_op stable from acceptance until the next acceptance; no other event changes them.
REQ-022 SHALL, in ISSUE, capture alu_z into out_z and alu_flags into out_flags on the next edge (one full cycle of ALU settling), then go to DONE.
REQ-023 SHALL assert out_valid exactly in DONE; latency is one cycle from the acceptance edge to out_valid high.
REQ-024 SHALL hold out_z/out_flags stable while out_valid & ~out_ready (back-pressure for any number of cycles).
REQ-025 SHALL, in DONE with out_ready=1: go to ISSUE with new operands if in_valid=1 (back-to-back, 1 result per 2 cycles); otherwise go to IDLE.
REQ-026 SHALL, in IDLE with in_valid=0, remain in IDLE; ISSUE always exits after exactly one cycle regardless of any input.
REQ-027 SHALL update status <= status | alu_flags on the ISSUE capture edge.
REQ-028 SHALL clear status to 0 on an edge with flag_clr=1; on an edge with both flag_clr and capture, status SHALL equal the newly captured alu_flags only.
REQ-029 SHALL treat an unknown opcode normally: whatever alu_flags reports (bit5) is captured and made sticky; there is no special-case handling.
REQ-030 SHALL ignore in_a/in_b/in_op whenever no acceptance occurs.

Reset
REQ-031 SHALL, while rst=1 (asynchronously, regardless of clk), force state=IDLE, out_valid=0, busy=0, out_z=0, out_flags=0, status=0, alu_a=alu_b=alu_op=0.
REQ-032 SHALL abort any in-flight or unaccepted result on reset; the request is discarded, and the stage resumes accepting one edge after rst deasserts.

Verification (bench attaches ALU with BITS=8, LOG2_BITS=3)
REQ-033 SHALL cover ADD: in_a=8'hF0, in_b=8'h20, in_op=8'h00 accepted at edge N -> out_valid high after edge N+1, out_z=8'h10, out_flags=8'h01, status=8'h01.
REQ-034 SHALL cover DIV by zero: in_a=8'h05, in_b=8'h00, in_op=8'h03 -> out_z=8'h00, out_flags=8'h10; status bit4 set and remaining set after a following AND (op 8'h05) with flags 8'h00.
REQ-035 SHALL cover back-pressure: out_ready=0 for 5 cycles after a result -> out_valid, out_z and out_flags held, in_ready=0, busy=1; out_ready=1 -> IDLE next edge.
REQ-036 SHALL cover back-to-back: in_valid=1 continuously, out_ready=1, four XORs -> results on alternate cycles, in order, none dropped or duplicated.
REQ-037 SHALL cover reset mid-operation: rst pulsed during ISSUE (asynchronous, between edges) -> out_valid=0 and status=0 immediately; no result is produced for that request.
REQ-038 SHALL cover clear collision: status=8'h01, flag_clr=1 on the capture edge of CMP 8'h07 vs 8'h07 (op 8'h84) -> status=8'h08, out_z=8'h01.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage between an upstream request port and a combinational ALU.
// Latency: result valid one cycle after the acceptance edge; one result per 2 cycles back-to-back.
// Backpressure: result is held while out_ready is low; new requests only accepted from IDLE or on a draining DONE.
module alu_issue_stage #(
  parameter int BITS      = 8,
  parameter int LOG2_BITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic [BITS-1:0] in_op,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [BITS-1:0] alu_op,
  input  logic [BITS-1:0] alu_z,
  input  logic [7:0]      alu_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_z,
  output logic [7:0]      out_flags,
  output logic [7:0]      status,
  input  logic            flag_clr,
  output logic            busy
);

  // The attached ALU is built with the same width pair; catch an inconsistent pair at elaboration.
  if ((1 << LOG2_BITS) != BITS) begin : g_log2_mismatch
    $error("alu_issue_stage: LOG2_BITS does not match BITS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] a_q, b_q, op_q;
  logic [BITS-1:0] z_q;
  logic [7:0]      flags_q;
  logic [7:0]      status_q, status_d;
  logic            accept;
  logic            capture;

  // Acceptance and capture strobes; ready is combinational from state and downstream ready.
  always_comb begin
    in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    accept   = in_valid & in_ready;
    capture  = (state_q == ISSUE);
  end

  // Next-state logic: ISSUE always lasts exactly one cycle to let the ALU settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flag accumulation; a clear on the capture edge keeps only the fresh flags.
  always_comb begin
    status_d = status_q;
    if (flag_clr) begin
      status_d = capture ? alu_flags : 8'h00;
    end else if (capture) begin
      status_d = status_q | alu_flags;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operands change only on acceptance, so the ALU inputs stay stable in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= in_a;
      b_q  <= in_b;
      op_q <= in_op;
    end
  end

  // Result capture at the end of ISSUE; held through any back-pressure in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q     <= '0;
      flags_q <= 8'h00;
    end else if (capture) begin
      z_q     <= alu_z;
      flags_q <= alu_flags;
    end
  end

  // Sticky status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status_q <= 8'h00;
    else     status_q <= status_d;
  end

  // Output drive.
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    out_z     = z_q;
    out_flags = flags_q;
    status    = status_q;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural 8-bit ALU attached.
// Scoreboard: expected results pushed at acceptance, popped at each output transfer.
module tb_alu_issue_stage;
  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [BITS-1:0] in_a, in_b, in_op;
  logic [BITS-1:0] alu_a, alu_b, alu_op, alu_z;
  logic [7:0]      alu_flags;
  logic            out_valid, out_ready;
  logic [BITS-1:0] out_z;
  logic [7:0]      out_flags, status;
  logic            flag_clr, busy;

  typedef struct packed {
    logic [7:0] z;
    logic [7:0] f;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  res_t sb[$];
  int   pop_cyc[$];

  alu_issue_stage #(.BITS(8), .LOG2_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .status(status), .flag_clr(flag_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU: flags {-,-,UNKNWN,DIV0,EQ,GT,UNDER,OVER}
  function automatic res_t alu_model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    res_t r;
    logic [8:0]  s;
    logic [15:0] m;
    r = '0;
    case (op[4:0])
      5'd0: begin s = {1'b0, a} + {1'b0, b}; r.z = s[7:0]; r.f[0] = s[8]; end
      5'd1: begin r.z = a - b; r.f[1] = (a < b); end
      5'd2: begin m = a * b; r.z = m[7:0]; r.f[0] = (m[15:8] != 8'h00); end
      5'd3: begin if (b == 8'h00) r.f[4] = 1'b1; else r.z = a / b; end
      5'd4: begin r.z = {7'b0, a == b}; r.f[3] = (a == b); r.f[2] = (a > b); end
      5'd5: r.z = a & b;
      5'd6: r.z = a | b;
      5'd7: r.z = a ^ b;
      default: r.f[5] = 1'b1;
    endcase
    return r;
  endfunction

  always_comb {alu_z, alu_flags} = alu_model(alu_a, alu_b, alu_op);

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor, sampled mid-cycle so values are those seen by the next rising edge.
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got z=%h flags=%h, expected no output", out_z, out_flags);
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          if (out_z !== e.z || out_flags !== e.f) begin
            bad++;
            $display("FAIL sb_result: got z=%h flags=%h, expected z=%h flags=%h", out_z, out_flags, e.z, e.f);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(alu_model(in_a, in_b, in_op));
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL issue_timeout: request op=%h never accepted", op);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; flag_clr = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, out_z, out_flags, status} !== 26'h0) begin
      bad++; $display("FAIL reset_out: got v=%b busy=%b z=%h f=%h st=%h, expected all 0", out_valid, busy, out_z, out_flags, status);
    end
    total++;
    if ({alu_a, alu_b, alu_op} !== 24'h0) begin
      bad++; $display("FAIL reset_alu: got %h %h %h, expected 0 0 0", alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    issue(8'hF0, 8'h20, 8'h00);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || {alu_a, alu_b, alu_op} !== 24'hF02000) begin
      bad++; $display("FAIL add_issue: got v=%b busy=%b ops=%h%h%h, expected 0 1 F02000", out_valid, busy, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_z !== 8'h10 || out_flags !== 8'h01 || status !== 8'h01) begin
      bad++; $display("FAIL add_result: got v=%b z=%h f=%h st=%h, expected 1 10 01 01", out_valid, out_z, out_flags, status);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL add_idle: got busy=%b rdy=%b, expected 0 1", busy, in_ready);
    end
  endtask

  task automatic test_div0();
    issue(8'h05, 8'h00, 8'h03);
    @(posedge clk); #1;
    total++;
    if (out_z !== 8'h00 || out_flags !== 8'h10 || status !== 8'h11) begin
      bad++; $display("FAIL div0: got z=%h f=%h st=%h, expected 00 10 11", out_z, out_flags, status);
    end
    issue(8'h3C, 8'h0F, 8'h05);
    @(posedge clk); #1;
    total++;
    if (out_z !== 8'h0C || out_flags !== 8'h00 || status !== 8'h11) begin
      bad++; $display("FAIL div0_sticky: got z=%h f=%h st=%h, expected 0C 00 11", out_z, out_flags, status);
    end
    wait_idle();
  endtask

  task automatic test_unknown();
    issue(8'h12, 8'h34, 8'h1F);
    @(posedge clk); #1;
    total++;
    if (out_flags !== 8'h20 || status !== 8'h31) begin
      bad++; $display("FAIL unknown_op: got f=%h st=%h, expected 20 31", out_flags, status);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    issue(8'hF0, 8'h20, 8'h00);
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || status !== 8'h00 || busy !== 1'b0 || alu_a !== 8'h00) begin
      bad++; $display("FAIL reset_mid: got v=%b st=%h busy=%b a=%h, expected 0 00 0 00", out_valid, status, busy, alu_a);
    end
    #2 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL reset_mid_post: got v=%b rdy=%b, expected 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(8'hA5, 8'h0F, 8'h07);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 8'h00;
      total++;
      if (out_valid !== 1'b1 || out_z !== 8'hAA || out_flags !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b1 || alu_a !== 8'hA5) begin
        bad++; $display("FAIL bp_hold: got v=%b z=%h f=%h rdy=%b busy=%b a=%h, expected 1 AA 00 0 1 A5", out_valid, out_z, out_flags, in_ready, busy, alu_a);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: got busy=%b v=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [4] = '{8'h11, 8'h5A, 8'hFF, 8'h80};
    logic [7:0] bv [4] = '{8'h22, 8'hA5, 8'h0F, 8'h81};
    int  n0;
    bit  acc;
    n0 = pop_cyc.size();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a = av[k]; in_b = bv[k]; in_op = 8'h07;
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin total++; bad++; $display("FAIL b2b_accept: request %0d not accepted", k); end
    end
    in_valid = 1'b0;
    wait_idle();
    total++;
    if (pop_cyc.size() - n0 !== 4 || sb.size() !== 0) begin
      bad++; $display("FAIL b2b_count: got %0d results pending=%0d, expected 4 pending=0", pop_cyc.size() - n0, sb.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (pop_cyc[n0+k] - pop_cyc[n0+k-1] !== 2) begin
          bad++; $display("FAIL b2b_spacing: got gap %0d, expected 2", pop_cyc[n0+k] - pop_cyc[n0+k-1]);
        end
      end
    end
  endtask

  task automatic test_clear_collision();
    issue(8'hF0, 8'h20, 8'h00);
    @(posedge clk); #1;
    total++;
    if (status !== 8'h01) begin bad++; $display("FAIL clr_setup: got st=%h expected 01", status); end
    wait_idle();
    issue(8'h07, 8'h07, 8'h84);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    total++;
    if (status !== 8'h08 || out_z !== 8'h01 || out_flags !== 8'h08) begin
      bad++; $display("FAIL clr_collide: got st=%h z=%h f=%h, expected 08 01 08", status, out_z, out_flags);
    end
    wait_idle();
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    total++;
    if (status !== 8'h00) begin bad++; $display("FAIL clr_alone: got st=%h expected 00", status); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div0();
    test_unknown();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_clear_collision();
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
